// File: rtl/line_buffer_bank_11_pkg.sv
// Shared image-pipeline constants for the 11x11 window line buffers.
//   KSIZE   : window height/width in pixels
//   PIX_W   : pixel width in bits
//   CNT_W   : width of the column/row counters
//   NSTORES : number of full-row line stores (the current row comes straight from the input)
//   TAPS_W  : width of the packed vertical tap vector
package line_buffer_bank_11_pkg;

  localparam int unsigned KSIZE   = 11;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned NSTORES = KSIZE - 1;
  localparam int unsigned TAPS_W  = KSIZE * PIX_W;

endpackage

// File: rtl/line_buffer_bank_11_line_store.sv
// line_store: one image row of pixels, single-port, read-before-write at a shared address.
// Ports:
//   clk     : rising-edge clock
//   we_i    : write enable; the entry at addr_i is replaced at the clock edge
//   addr_i  : column address
//   wdata_i : pixel to store
//   rdata_o : pixel currently held at addr_i (old value during a write cycle)
// Contents are never reset so the array can map onto RAM.
module line_buffer_bank_11_line_store
  import line_buffer_bank_11_pkg::*;
#(
  parameter int unsigned COLS = 640
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [CNT_W-1:0] addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);

  localparam int unsigned AW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [PIX_W-1:0] mem_q [COLS];
  logic [AW-1:0]    addr;

  assign addr = addr_i[AW-1:0];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr] <= wdata_i;
    end
  end

  // The old entry is visible in the same cycle so it can cascade into the next store.
  assign rdata_o = mem_q[addr];

endmodule

// File: rtl/line_buffer_bank_11.sv
// Ten-row line buffer bank feeding an 11x11 window: for every accepted raster pixel it emits
// the 11 vertically aligned pixels of that column, oldest row in byte 0, current row in byte 10.
// Ports:
//   clk           : rising-edge clock
//   rst_n         : synchronous active-low reset (line store contents are kept)
//   frame_start_i : pulse that clears the column/row counters (takes effect for a same-cycle pixel)
//   pixel_i       : raster-order pixel
//   valid_i       : pixel_i qualifier; low cycles stall the pipeline
//   taps_o        : 11 packed pixels, byte k = row r-10+k of the accepted column
//   taps_valid_o  : taps_o carries a column with 11 rows of the current frame
//   col_o         : column index of the column on taps_o
//   frame_done_o  : one-cycle pulse alongside the taps of the last frame pixel
module line_buffer_bank_11
  import line_buffer_bank_11_pkg::*;
#(
  parameter int unsigned COLS = 640,
  parameter int unsigned ROWS = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start_i,
  input  logic [PIX_W-1:0]  pixel_i,
  input  logic              valid_i,
  output logic [TAPS_W-1:0] taps_o,
  output logic              taps_valid_o,
  output logic [CNT_W-1:0]  col_o,
  output logic              frame_done_o
);

  logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
  logic [TAPS_W-1:0] taps_q, taps_d;
  logic              taps_valid_q, taps_valid_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic              frame_done_q, frame_done_d;

  logic              accept;
  logic [CNT_W-1:0]  col_eff, row_eff;
  logic              last_col, last_row;

  logic [PIX_W-1:0]  wdata [NSTORES];
  logic [PIX_W-1:0]  rdata [NSTORES];

  // A pixel presented during reset is dropped so the discarded frame leaves no trace.
  assign accept = valid_i & rst_n;

  // frame_start_i clears the counters before a coincident pixel is addressed.
  assign col_eff  = frame_start_i ? '0 : col_cnt_q;
  assign row_eff  = frame_start_i ? '0 : row_cnt_q;
  assign last_col = (col_eff == CNT_W'(COLS - 1));
  assign last_row = (row_eff == CNT_W'(ROWS - 1));

  // Store 0 takes the new pixel; store k takes the row store k-1 held, shifting rows down.
  always_comb begin
    wdata[0] = pixel_i;
    for (int k = 1; k < NSTORES; k++) begin
      wdata[k] = rdata[k-1];
    end
  end

  for (genvar g = 0; g < NSTORES; g++) begin : g_store
    line_buffer_bank_11_line_store #(
      .COLS (COLS)
    ) u_line_store (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (col_eff),
      .wdata_i (wdata[g]),
      .rdata_o (rdata[g])
    );
  end

  always_comb begin
    col_cnt_d    = col_eff;
    row_cnt_d    = row_eff;
    taps_d       = taps_q;
    col_d        = col_q;
    taps_valid_d = 1'b0;
    frame_done_d = 1'b0;

    if (accept) begin
      if (last_col) begin
        col_cnt_d = '0;
        // The last pixel of the frame rewinds both counters for the next frame.
        row_cnt_d = last_row ? '0 : row_eff + CNT_W'(1);
      end else begin
        col_cnt_d = col_eff + CNT_W'(1);
      end

      taps_d[(KSIZE-1)*PIX_W +: PIX_W] = pixel_i;
      for (int k = 1; k < KSIZE; k++) begin
        taps_d[(KSIZE-1-k)*PIX_W +: PIX_W] = rdata[k-1];
      end

      col_d        = col_eff;
      taps_valid_d = (row_eff >= CNT_W'(KSIZE - 1));
      frame_done_d = last_col & last_row;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      taps_q       <= '0;
      taps_valid_q <= 1'b0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      taps_q       <= taps_d;
      taps_valid_q <= taps_valid_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign taps_o       = taps_q;
  assign taps_valid_o = taps_valid_q;
  assign col_o        = col_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_line_buffer_bank_11.sv
// Directed bench for line_buffer_bank_11 with a 16x16 frame and pixel = (row*16+col) & 0xFF.
module tb_line_buffer_bank_11;

  localparam int C = 16;
  localparam int R = 16;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [7:0]  pixel;
  logic        valid;
  logic [87:0] taps;
  logic        taps_valid;
  logic [9:0]  col;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  line_buffer_bank_11 #(
    .COLS (C),
    .ROWS (R)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start),
    .pixel_i       (pixel),
    .valid_i       (valid),
    .taps_o        (taps),
    .taps_valid_o  (taps_valid),
    .col_o         (col),
    .frame_done_o  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r * 16 + c) & 255);
  endfunction

  // Expected column for pixel (r,c): byte k holds pixel (r-10+k, c).
  function automatic logic [87:0] exp_taps(input int r, input int c);
    logic [87:0] t;
    for (int k = 0; k < 11; k++) t[k*8 +: 8] = pix(r - 10 + k, c);
    return t;
  endfunction

  // Present one input cycle, then sample 1 time unit after the edge.
  task automatic tick(input logic v, input logic fs, input logic [7:0] p);
    valid       = v;
    frame_start = fs;
    pixel       = p;
    @(posedge clk);
    #1;
    valid       = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h55);
    n_cmp++; if (taps !== 88'h0) begin n_err++; $display("FAIL reset_taps: got %h want 0", taps); end
    n_cmp++; if (taps_valid !== 1'b0) begin n_err++; $display("FAIL reset_tv: got %b want 0", taps_valid); end
    n_cmp++; if (col !== 10'd0) begin n_err++; $display("FAIL reset_col: got %0d want 0", col); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", frame_done); end
    rst_n = 1'b1;
  endtask

  task automatic test_continuous();
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        tick(1'b1, 1'b0, pix(r, c));
        n_cmp++; if (taps_valid !== (r >= 10)) begin n_err++;
          $display("FAIL cont_tv (%0d,%0d): got %b want %b", r, c, taps_valid, r >= 10); end
        n_cmp++; if (col !== 10'(c)) begin n_err++;
          $display("FAIL cont_col (%0d,%0d): got %0d want %0d", r, c, col, c); end
        n_cmp++; if (frame_done !== (r == R - 1 && c == C - 1)) begin n_err++;
          $display("FAIL cont_done (%0d,%0d): got %b", r, c, frame_done); end
        if (r >= 10) begin
          n_cmp++; if (taps !== exp_taps(r, c)) begin n_err++;
            $display("FAIL cont_taps (%0d,%0d): got %h want %h", r, c, taps, exp_taps(r, c)); end
        end
        if (r == 10 && c == 0) begin
          n_cmp++; if (taps[87:80] !== 8'hA0) begin n_err++;
            $display("FAIL first_b10: got %h want a0", taps[87:80]); end
        end
        if (r == R - 1 && c == C - 1) begin
          n_cmp++; if (taps[87:80] !== 8'hFF) begin n_err++;
            $display("FAIL last_b10: got %h want ff", taps[87:80]); end
          n_cmp++; if (taps[7:0] !== 8'h5F) begin n_err++;
            $display("FAIL last_b0: got %h want 5f", taps[7:0]); end
        end
      end
    end
    tick(1'b0, 1'b0, 8'h00);
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL done_single: got %b want 0", frame_done); end
    n_cmp++; if (taps_valid !== 1'b0) begin n_err++; $display("FAIL post_tv: got %b want 0", taps_valid); end
  endtask

  // Second frame with no frame_start: relies on the auto-rewind after frame_done.
  task automatic test_back_to_back();
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        tick(1'b1, 1'b0, pix(r, c));
        n_cmp++; if (taps_valid !== (r >= 10)) begin n_err++;
          $display("FAIL b2b_tv (%0d,%0d): got %b want %b", r, c, taps_valid, r >= 10); end
        n_cmp++; if (col !== 10'(c)) begin n_err++;
          $display("FAIL b2b_col (%0d,%0d): got %0d want %0d", r, c, col, c); end
        if (r == 10 && c == 0) begin
          n_cmp++; if (taps !== exp_taps(10, 0)) begin n_err++;
            $display("FAIL b2b_taps: got %h want %h", taps, exp_taps(10, 0)); end
        end
        if (r == R - 1 && c == C - 1) begin
          n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", frame_done); end
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        tick(1'b1, 1'b0, pix(r, c));
        n_cmp++; if (taps_valid !== (r >= 10)) begin n_err++;
          $display("FAIL stall_tv (%0d,%0d): got %b want %b", r, c, taps_valid, r >= 10); end
        n_cmp++; if (frame_done !== (r == R - 1 && c == C - 1)) begin n_err++;
          $display("FAIL stall_done (%0d,%0d): got %b", r, c, frame_done); end
        if (r >= 10) begin
          n_cmp++; if (taps !== exp_taps(r, c)) begin n_err++;
            $display("FAIL stall_taps (%0d,%0d): got %h want %h", r, c, taps, exp_taps(r, c)); end
        end
        tick(1'b0, 1'b0, 8'hEE);
        n_cmp++; if (taps_valid !== 1'b0) begin n_err++;
          $display("FAIL stall_gap_tv (%0d,%0d): got %b want 0", r, c, taps_valid); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++;
          $display("FAIL stall_gap_done (%0d,%0d): got %b want 0", r, c, frame_done); end
        n_cmp++; if (col !== 10'(c)) begin n_err++;
          $display("FAIL stall_hold_col (%0d,%0d): got %0d want %0d", r, c, col, c); end
        if (r >= 10) begin
          n_cmp++; if (taps !== exp_taps(r, c)) begin n_err++;
            $display("FAIL stall_hold_taps (%0d,%0d): got %h want %h", r, c, taps, exp_taps(r, c)); end
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 12 * C + 5; i++) tick(1'b1, 1'b0, pix(i / C, i % C));
    rst_n = 1'b0;
    tick(1'b1, 1'b0, pix(12, 5));
    rst_n = 1'b1;
    n_cmp++; if (taps !== 88'h0) begin n_err++; $display("FAIL mid_rst_taps: got %h want 0", taps); end
    n_cmp++; if (taps_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_tv: got %b want 0", taps_valid); end
    n_cmp++; if (col !== 10'd0) begin n_err++; $display("FAIL mid_rst_col: got %0d want 0", col); end
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        tick(1'b1, 1'b0, pix(r, c));
        n_cmp++; if (taps_valid !== (r >= 10)) begin n_err++;
          $display("FAIL mid_tv (%0d,%0d): got %b want %b", r, c, taps_valid, r >= 10); end
        n_cmp++; if (col !== 10'(c)) begin n_err++;
          $display("FAIL mid_col (%0d,%0d): got %0d want %0d", r, c, col, c); end
        if (r >= 10) begin
          n_cmp++; if (taps !== exp_taps(r, c)) begin n_err++;
            $display("FAIL mid_taps (%0d,%0d): got %h want %h", r, c, taps, exp_taps(r, c)); end
        end
      end
    end
  endtask

  task automatic test_frame_start();
    for (int i = 0; i < 3 * C + 7; i++) tick(1'b1, 1'b0, pix(i / C, i % C));
    // Pixel that would have been (3,7) restarts the frame as (0,0).
    tick(1'b1, 1'b1, pix(0, 0));
    n_cmp++; if (col !== 10'd0) begin n_err++; $display("FAIL fs_col: got %0d want 0", col); end
    n_cmp++; if (taps_valid !== 1'b0) begin n_err++; $display("FAIL fs_tv: got %b want 0", taps_valid); end
    for (int i = 1; i < R * C; i++) begin
      int r, c;
      r = i / C;
      c = i % C;
      tick(1'b1, 1'b0, pix(r, c));
      n_cmp++; if (taps_valid !== (r >= 10)) begin n_err++;
        $display("FAIL fs_run_tv (%0d,%0d): got %b want %b", r, c, taps_valid, r >= 10); end
      n_cmp++; if (col !== 10'(c)) begin n_err++;
        $display("FAIL fs_run_col (%0d,%0d): got %0d want %0d", r, c, col, c); end
      n_cmp++; if (frame_done !== (i == R * C - 1)) begin n_err++;
        $display("FAIL fs_run_done (%0d,%0d): got %b", r, c, frame_done); end
      if (r >= 10) begin
        n_cmp++; if (taps !== exp_taps(r, c)) begin n_err++;
          $display("FAIL fs_run_taps (%0d,%0d): got %h want %h", r, c, taps, exp_taps(r, c)); end
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    valid       = 1'b0;
    pixel       = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_continuous();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    test_frame_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_buffer_bank_11.md
LINE_BUFFER_BANK_11 -- requirements
Module: line_buffer_bank_11

Interface
REQ-001 SHALL have parameter COLS, default 640, meaning pixels per image row (range 12..1024).
REQ-002 SHALL have parameter ROWS, default 480, meaning rows per frame (range 11..1024).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port frame_start_i  input  1  single-cycle pulse; clears column/row counters.
REQ-006 SHALL have port pixel_i  input  8  raster-order pixel.
REQ-007 SHALL have port valid_i  input  1  pixel_i qualifier; may drop at any time (stall).
REQ-008 SHALL have port taps_o  output  88  11 vertically aligned pixels; byte k = row (r-10+k), byte 0 = oldest/top row, byte 10 = current row.
REQ-009 SHALL have port taps_valid_o  output  1  taps_o holds a full 11-row column.
REQ-010 SHALL have port col_o  output  10  column index of the column on taps_o.
REQ-011 SHALL have port frame_done_o  output  1  one-cycle pulse with the last column of the frame.

Function
REQ-012 SHALL hold 10 line stores of COLS x 8 bits sharing one column pointer col_cnt.
REQ-013 SHALL, on each cycle with valid_i=1, read all 10 stores at col_cnt and write pixel_i to store 0 and old store k-1 data to store k (read-before-write, same address).
REQ-014 SHALL register taps_o one cycle after the accepted pixel: byte 10 = pixel_i, byte 10-k = old store k-1 data at col_cnt.
REQ-015 SHALL hold taps_o, col_o, taps_valid_o=0 on cycles following valid_i=0 (no re-emission).
REQ-016 SHALL increment col_cnt per accepted pixel, wrap COLS-1 -> 0, and increment row_cnt on that wrap.
REQ-017 SHALL assert taps_valid_o one cycle after an accepted pixel whose row_cnt >= 10; else 0.
REQ-018 SHALL assert frame_done_o together with the taps of pixel (ROWS-1, COLS-1), then clear col_cnt and row_cnt to 0.
REQ-019 SHALL, when frame_start_i and valid_i coincide, clear counters first and accept the pixel as (row 0, col 0).
REQ-020 SHALL ignore valid_i pulses beyond the frame end until counters are restarted (auto-cleared per REQ-018).
REQ-021 SHALL not clear line store contents on frame_start_i or reset; stale rows are masked by taps_valid_o.
REQ-022 SHALL use 10-bit unsigned counters; col_o equals col_cnt of the accepted pixel.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, set taps_o=0, taps_valid_o=0, col_o=0, frame_done_o=0, col_cnt=0, row_cnt=0.
REQ-024 SHALL, on reset mid-frame, discard the frame; next frame starts at (0,0) with taps_valid_o low for 10 rows.
REQ-025 SHALL not require reset of line store RAM (inferable as block RAM).

Structure
REQ-026 SHALL place KSIZE=11, PIX_W=8, CNT_W=10 in the shared image-pipeline package used by the window buffers.
REQ-027 SHALL instantiate one sub-module line_store (single-port read-before-write, COLS x 8) ten times via generate.
REQ-028 SHALL connect taps_o bytes 0..10 directly to the 11x11 window buffer row inputs S1..S11.

Verification
REQ-029 SHALL test COLS=16, ROWS=16, pixel=(row*16+col)&0xFF continuous: first taps_valid_o at pixel (10,0), taps_o byte k=(k*16)&0xFF, byte 10=0xA0.
REQ-030 SHALL test same stream: frame_done_o single pulse with taps of (15,15), byte 10=0xFF, byte 0=0x5F; counters then 0.
REQ-031 SHALL test valid_i toggled 1/0 every cycle: taps_o sequence identical to REQ-029, taps_valid_o never high on stall-following cycles.
REQ-032 SHALL test rst_n low at pixel (12,5) then new frame: no taps_valid_o until row 10 of new frame.
REQ-033 SHALL test frame_start_i with valid_i at pixel (3,7): that pixel reported col_o=0, taps_valid_o first high 10 rows later.
REQ-034 SHALL test back-to-back frames: second frame taps_valid_o rises exactly at its pixel (10,0).
